// File: rtl/ram_arbiter.sv
// ram_arbiter: lets the CPU and the DMA engine share the single-port data RAM.
//
// Each access is a req/ack handshake. When both sides request at once the grant alternates
// (round-robin). The DMA can hold the bus for a burst by raising dma_lock_i, but only for
// MAX_LOCK grants in a row while the CPU is waiting, so the CPU is never starved.
// Optional feature: define ARB_STATS_EN to add conflict_cnt_o.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   conflict_cnt_o             (ARB_STATS_EN only) number of IDLE cycles with both requests
//                              high; stops counting at 0xFFFF
//   cpu_req_i/we_i/addr_i/     CPU request and access fields, held until cpu_ack_o
//   wdata_i
//   cpu_ack_o, cpu_rdata_o     one-cycle completion pulse; read data, valid with the ack
//   dma_req_i/we_i/addr_i/     DMA request and access fields, held until dma_ack_o
//   wdata_i, dma_lock_i        dma_lock_i asks to keep the bus for the next DMA access
//   dma_ack_o, dma_rdata_o     one-cycle completion pulse; read data, valid with the ack
//   ram_cs_o/we_o/addr_o/      registered RAM controls
//   wdata_o
//   ram_rdata_i                RAM read data, valid one cycle after ram_cs_o
module ram_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
`ifdef ARB_STATS_EN
    output logic [15:0]       conflict_cnt_o,
`endif
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    input  logic              dma_lock_i,
    output logic              dma_ack_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int unsigned LockW = $clog2(MAX_LOCK + 1);
    localparam logic [LockW-1:0] MaxLock = LockW'(MAX_LOCK);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    state_e            state_q, state_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt_dma_q, gnt_dma_d;    // owner of the access in flight
    logic              last_dma_q, last_dma_d;  // owner of the most recent grant
    logic              lock_q, lock_d;          // dma_lock_i seen at the last DMA grant
    logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic lock_win;
    logic pick_dma;

    // The lock only decides ties; a lone requester always wins.
    assign lock_win = last_dma_q & lock_q & (lock_cnt_q < MaxLock);
    assign pick_dma = dma_req_i & (~cpu_req_i | lock_win | ~last_dma_q);

    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_dma_d   = gnt_dma_q;
        last_dma_d  = last_dma_q;
        lock_d      = lock_q;
        lock_cnt_d  = lock_cnt_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i || dma_req_i) begin
                    state_d    = StAccess;
                    cs_d       = 1'b1;
                    gnt_dma_d  = pick_dma;
                    last_dma_d = pick_dma;
                    if (pick_dma) begin
                        we_d    = dma_we_i;
                        addr_d  = dma_addr_i;
                        wdata_d = dma_wdata_i;
                        lock_d  = dma_lock_i;
                        // Count only the locked grants taken while the CPU is waiting.
                        if (!cpu_req_i) begin
                            lock_cnt_d = '0;
                        end else if (dma_lock_i && (lock_cnt_q < MaxLock)) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                    end else begin
                        we_d       = cpu_we_i;
                        addr_d     = cpu_addr_i;
                        wdata_d    = cpu_wdata_i;
                        lock_cnt_d = '0;
                    end
                end
            end
            StAccess: begin
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
                // Read data is latched for writes as well; the requester ignores it.
                if (gnt_dma_q) begin
                    dma_ack_d   = 1'b1;
                    dma_rdata_d = ram_rdata_i;
                end else begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = ram_rdata_i;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_dma_q   <= 1'b0;
            last_dma_q  <= 1'b1;  // CPU wins the first tie after reset
            lock_q      <= 1'b0;
            lock_cnt_q  <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_dma_q   <= gnt_dma_d;
            last_dma_q  <= last_dma_d;
            lock_q      <= lock_d;
            lock_cnt_q  <= lock_cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= '0;
        end else if ((state_q == StIdle) && cpu_req_i && dma_req_i &&
                     (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt_o = conflict_q;
`endif

    assign cpu_ack_o   = cpu_ack_q;
    assign dma_ack_o   = dma_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign ram_cs_o    = cs_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MAX_LOCK=4) with a small synchronous RAM model.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [7:0] dma_addr = '0, dma_wdata = '0;
    logic       dma_ack;
    logic [7:0] dma_rdata;
    logic       ram_cs, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_who[$];  // 0 = CPU, 1 = DMA
    int ack_cyc[$];

    logic [7:0] mem [256];
    logic       bd_en = 1'b0;
    logic [7:0] bd_addr = '0, bd_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    ram_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .MAX_LOCK(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
`ifdef ARB_STATS_EN
        .conflict_cnt_o(conflict_cnt),
`endif
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_ack_o     (cpu_ack),
        .cpu_rdata_o   (cpu_rdata),
        .dma_req_i     (dma_req),
        .dma_we_i      (dma_we),
        .dma_addr_i    (dma_addr),
        .dma_wdata_i   (dma_wdata),
        .dma_lock_i    (dma_lock),
        .dma_ack_o     (dma_ack),
        .dma_rdata_o   (dma_rdata),
        .ram_cs_o      (ram_cs),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata)
    );

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        @(posedge clk); #1;
        bd_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int seen = 0;
        int b = 0;
        ack_who.delete();
        ack_cyc.delete();
        while (seen < n && b < budget) begin
            @(posedge clk); #1;
            b++;
            checks++;
            if (cpu_ack && dma_ack) begin
                errors++;
                $display("FAIL dual_ack got both acks high want at most one");
            end
            if (cpu_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); seen++; end
            if (dma_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); seen++; end
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL ack_timeout got %0d acks want %0d", seen, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", ram_cs); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", ram_we); end
        checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", ram_addr); end
        checks++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
            errors++; $display("FAIL rst_ack got %b%b want 00", cpu_ack, dma_ack); end
        checks++; if (cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin
            errors++; $display("FAIL rst_rdata got %h/%h want 00/00", cpu_rdata, dma_rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL idle_cs got %b want 0", ram_cs); end
    endtask

    task automatic test_cpu_read();
        preload(8'h10, 8'h5A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL rd_cs got %b want 1", ram_cs); end
        checks++; if (ram_addr !== 8'h10) begin errors++; $display("FAIL rd_addr got %h want 10", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b want 0", ram_we); end
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL rd_cs_drop got %b want 0", ram_cs); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_early got %b want 0", cpu_ack); end
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data got %h want 5a", cpu_rdata); end
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rd_dma_ack got %b want 0", dma_ack); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data_hold got %h want 5a", cpu_rdata); end
        checks++; if (ram_addr !== 8'h10 || ram_cs !== 1'b0) begin
            errors++; $display("FAIL rd_addr_hold got %h cs %b want 10 cs 0", ram_addr, ram_cs); end
    endtask

    task automatic test_dma_write_cpu_read();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'hA5; dma_lock = 1'b0;
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin
            errors++; $display("FAIL wr_cs_we got %b%b want 11", ram_cs, ram_we); end
        checks++; if (ram_addr !== 8'h20 || ram_wdata !== 8'hA5) begin
            errors++; $display("FAIL wr_fields got %h/%h want 20/a5", ram_addr, ram_wdata); end
        wait_acks(1, 10);
        dma_req = 1'b0; dma_we = 1'b0;
        checks++; if (ack_who.size() != 1 || ack_who[0] != 1) begin
            errors++; $display("FAIL wr_ack_owner got size %0d want one DMA ack", ack_who.size()); end
        checks++; if (mem[8'h20] !== 8'hA5) begin errors++; $display("FAIL wr_mem got %h want a5", mem[8'h20]); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        wait_acks(1, 10);
        cpu_req = 1'b0;
        checks++; if (ack_who.size() != 1 || ack_who[0] != 0) begin
            errors++; $display("FAIL rb_ack_owner got size %0d want one CPU ack", ack_who.size()); end
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rb_data got %h want a5", cpu_rdata); end
    endtask

    task automatic test_round_robin();
        int exp_who[4] = '{0, 1, 0, 1};
        do_reset();
        cpu_req = 1'b1; cpu_addr = 8'h01;
        dma_req = 1'b1; dma_addr = 8'h02; dma_lock = 1'b0;
        wait_acks(4, 30);
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 4 && i < ack_who.size(); i++) begin
            checks++;
            if (ack_who[i] != exp_who[i]) begin
                errors++; $display("FAIL rr_owner[%0d] got %0d want %0d", i, ack_who[i], exp_who[i]);
            end
            if (i > 0) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != 3) begin
                    errors++; $display("FAIL rr_gap[%0d] got %0d want 3", i, ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_lock_burst();
        int exp_who[7] = '{0, 1, 1, 1, 1, 0, 1};
        do_reset();
        cpu_req = 1'b1; cpu_addr = 8'h03;
        dma_req = 1'b1; dma_addr = 8'h04; dma_lock = 1'b1;
        wait_acks(7, 40);
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        for (int i = 0; i < 7 && i < ack_who.size(); i++) begin
            checks++;
            if (ack_who[i] != exp_who[i]) begin
                errors++; $display("FAIL lock_owner[%0d] got %0d want %0d", i, ack_who[i], exp_who[i]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        wait_acks(1, 10);  // last grant now CPU
        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL abort_pre_cs got %b want 1", ram_cs); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL abort_cs got %b want 0", ram_cs); end
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
                errors++; $display("FAIL abort_ack[%0d] got %b%b want 00", i, cpu_ack, dma_ack);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
        wait_acks(1, 10);
        cpu_req = 1'b0; dma_req = 1'b0;
        checks++; if (ack_who.size() != 1 || ack_who[0] != 0) begin
            errors++; $display("FAIL abort_first_tie got %0d acks want one CPU ack", ack_who.size()); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_reset got %0d want 0", conflict_cnt); end
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
        wait_acks(10, 50);
        cpu_req = 1'b0; dma_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (conflict_cnt !== 16'd10) begin
            errors++; $display("FAIL stats_count got %0d want 10", conflict_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write_cpu_read();
        test_round_robin();
        test_lock_burst();
        test_reset_mid_access();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
